change_dispenser: RTL

//  Downstream of the vending FSM. Takes the change amount it reports (0-4 units,
//  3-bit code) and pays it out through two coin hoppers: 2-unit and 1-unit.

---
 rtl/change_dispenser_if.sv | 25 ++
 rtl/change_dispenser.sv | 118 +++++++++++
 2 files changed

// File: rtl/change_dispenser_if.sv
// change_dispenser_if: change request, hopper status, solenoid and status signals of the change dispenser
interface change_dispenser_if;
    logic       chg_valid;
    logic [2:0] chg_amt;
    logic       hop2_empty;
    logic       hop1_empty;
    logic       drop_det;
    logic       fault_clr;
    logic       chg_ready;
    logic       busy;
    logic       eject2;
    logic       eject1;
    logic       done;
    logic       fault;
    logic [2:0] owed;
    logic       ovr_err;
    modport master (
        output chg_valid, chg_amt, hop2_empty, hop1_empty, drop_det, fault_clr,
        input  chg_ready, busy, eject2, eject1, done, fault, owed, ovr_err
    );
    modport slave (
        input  chg_valid, chg_amt, hop2_empty, hop1_empty, drop_det, fault_clr,
        output chg_ready, busy, eject2, eject1, done, fault, owed, ovr_err
    );
endinterface

// File: rtl/change_dispenser.sv
// change_dispenser: pays out 0-4 units via 2-unit and 1-unit hoppers, confirming each coin drop
module change_dispenser #(
    parameter int PULSE_CYC = 4,
    parameter int GAP_CYC   = 4,
    parameter int TO_CYC    = 64
) (
    input logic clk,
    input logic rst,
    change_dispenser_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SELECT, PULSE, WAIT_DROP, GAP, DONE, FAULT} state_t;
    localparam int MX = (PULSE_CYC > GAP_CYC ? (PULSE_CYC > TO_CYC ? PULSE_CYC : TO_CYC)
                                             : (GAP_CYC > TO_CYC ? GAP_CYC : TO_CYC));
    localparam int CW = $clog2(MX + 1);
    state_t        r_state;
    logic [2:0]    r_rem;
    logic [2:0]    r_owed;
    logic [1:0]    r_sel;
    logic [CW-1:0] r_cnt;
    logic          r_drop_seen;
    logic          r_eject2;
    logic          r_eject1;
    logic          r_done;
    logic          r_fault;
    logic          r_busy;
    logic          r_ovr;
    logic [2:0]    w_amt;
    assign w_amt = (bus.chg_amt > 3'd4) ? 3'd4 : bus.chg_amt;
    assign bus.chg_ready = ~r_busy;
    assign bus.busy      = r_busy;
    assign bus.eject2    = r_eject2;
    assign bus.eject1    = r_eject1;
    assign bus.done      = r_done;
    assign bus.fault     = r_fault;
    assign bus.owed      = r_owed;
    assign bus.ovr_err   = r_ovr;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_sel       <= '0;
            r_cnt       <= '0;
            r_owed      <= '0;
            r_drop_seen <= 1'b0;
            r_eject2    <= 1'b0;
            r_eject1    <= 1'b0;
            r_done      <= 1'b0;
            r_fault     <= 1'b0;
            r_busy      <= 1'b0;
            r_ovr       <= 1'b0;
        end else begin
            r_ovr  <= bus.chg_valid && (r_state != IDLE);
            r_done <= 1'b0;
            case (r_state)
                IDLE: if (bus.chg_valid && bus.chg_amt != 3'd0) begin
                    r_rem   <= w_amt;
                    r_busy  <= 1'b1;
                    r_state <= SELECT;
                end
                SELECT: begin
                    r_cnt       <= '0;
                    r_drop_seen <= 1'b0;
                    if (r_rem == 3'd0) begin
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else if (r_rem >= 3'd2 && !bus.hop2_empty) begin
                        r_sel    <= 2'd2;
                        r_eject2 <= 1'b1;
                        r_state  <= PULSE;
                    end else if (!bus.hop1_empty) begin
                        r_sel    <= 2'd1;
                        r_eject1 <= 1'b1;
                        r_state  <= PULSE;
                    end else begin
                        r_owed  <= r_rem;
                        r_fault <= 1'b1;
                        r_state <= FAULT;
                    end
                end
                PULSE: begin
                    if (bus.drop_det) r_drop_seen <= 1'b1;
                    if (r_cnt == CW'(PULSE_CYC - 1)) begin
                        r_cnt    <= '0;
                        r_eject2 <= 1'b0;
                        r_eject1 <= 1'b0;
                        r_state  <= WAIT_DROP;
                    end else r_cnt <= r_cnt + 1'b1;
                end
                // A drop latched during the pulse still costs one WAIT_DROP cycle before the gap.
                WAIT_DROP: if (r_drop_seen || bus.drop_det) begin
                    r_rem       <= r_rem - {1'b0, r_sel};
                    r_drop_seen <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= GAP;
                end else if (r_cnt == CW'(TO_CYC - 1)) begin
                    r_owed  <= r_rem;
                    r_fault <= 1'b1;
                    r_state <= FAULT;
                end else r_cnt <= r_cnt + 1'b1;
                GAP: if (r_cnt == CW'(GAP_CYC - 1)) begin
                    r_cnt   <= '0;
                    r_state <= SELECT;
                end else r_cnt <= r_cnt + 1'b1;
                DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                FAULT: if (bus.fault_clr) begin
                    r_owed  <= '0;
                    r_fault <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
